// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one external combinational ALU between two
// requesters: one operation in flight, operands and results held in registers.
module alu_arbiter #(
  parameter int W    = 32,
  parameter int FN_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0]      req_valid_i,
  output logic [1:0]      req_ready_o,
  input  logic [W-1:0]    req_a0_i,
  input  logic [W-1:0]    req_b0_i,
  input  logic [W-1:0]    req_a1_i,
  input  logic [W-1:0]    req_b1_i,
  input  logic [FN_W-1:0] req_fn0_i,
  input  logic [FN_W-1:0] req_fn1_i,
  output logic [W-1:0]    alu_a_o,
  output logic [W-1:0]    alu_b_o,
  output logic [FN_W-1:0] alu_fn_o,
  input  logic [W-1:0]    alu_r_i,
  input  logic            alu_cf_i,
  input  logic            alu_zf_i,
  input  logic            alu_vf_i,
  input  logic            alu_sf_i,
  output logic [1:0]      resp_valid_o,
  input  logic [1:0]      resp_ready_i,
  output logic [W-1:0]    resp_r_o,
  output logic [3:0]      resp_flags_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            prio_q, prio_d;
  logic            gnt_q, gnt_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d, r_q, r_d;
  logic [FN_W-1:0] fn_q, fn_d;
  logic [3:0]      flags_q, flags_d;
  logic [1:0]      resp_valid_q, resp_valid_d;
  logic            busy_q, busy_d;
  logic            sel_s;
  logic [1:0]      ready_s;

  // Grant decode: a lone request wins outright, a tie goes to the priority pointer.
  always_comb begin
    sel_s   = 1'b0;
    ready_s = 2'b00;
    if (state_q == IDLE) begin
      case (req_valid_i)
        2'b01: begin
          sel_s   = 1'b0;
          ready_s = 2'b01;
        end
        2'b10: begin
          sel_s   = 1'b1;
          ready_s = 2'b10;
        end
        2'b11: begin
          sel_s   = prio_q;
          ready_s = prio_q ? 2'b10 : 2'b01;
        end
        default: begin
          sel_s   = 1'b0;
          ready_s = 2'b00;
        end
      endcase
    end else begin
      sel_s   = 1'b0;
      ready_s = 2'b00;
    end
  end

  // Sequencer next state: accept, drive the ALU for one cycle, hold the response.
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    gnt_d   = gnt_q;
    a_d     = a_q;
    b_d     = b_q;
    fn_d    = fn_q;
    r_d     = r_q;
    flags_d = flags_q;
    case (state_q)
      IDLE: begin
        if (ready_s != 2'b00) begin
          gnt_d   = sel_s;
          prio_d  = ~sel_s;
          a_d     = sel_s ? req_a1_i  : req_a0_i;
          b_d     = sel_s ? req_b1_i  : req_b0_i;
          fn_d    = sel_s ? req_fn1_i : req_fn0_i;
          state_d = EXEC;
        end else begin
          state_d = IDLE;
        end
      end
      EXEC: begin
        r_d     = alu_r_i;
        flags_d = {alu_cf_i, alu_zf_i, alu_vf_i, alu_sf_i};
        state_d = RESP;
      end
      RESP: begin
        if (resp_ready_i[gnt_d]) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Registered outputs are computed from the upcoming state so they line up with it.
    if (state_d == RESP) begin
      resp_valid_d = gnt_d ? 2'b10 : 2'b01;
    end else begin
      resp_valid_d = 2'b00;
    end
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      prio_q       <= 1'b0;
      gnt_q        <= 1'b0;
      a_q          <= {W{1'b0}};
      b_q          <= {W{1'b0}};
      fn_q         <= {FN_W{1'b0}};
      r_q          <= {W{1'b0}};
      flags_q      <= 4'b0000;
      resp_valid_q <= 2'b00;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      gnt_q        <= gnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      fn_q         <= fn_d;
      r_q          <= r_d;
      flags_q      <= flags_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready_o  = ready_s;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_fn_o     = fn_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_r_o     = r_q;
  assign resp_flags_o = flags_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: reference ALU, transaction-level model checked every cycle,
// and directed scenarios with hand-computed literal expectations.
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [31:0] req_a0 = 32'd0, req_b0 = 32'd0, req_a1 = 32'd0, req_b1 = 32'd0;
  logic [3:0]  req_fn0 = 4'd0, req_fn1 = 4'd0;
  logic [31:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_fn, alu_fl;
  logic [1:0]  resp_valid;
  logic [1:0]  resp_ready = 2'b11;
  logic [31:0] resp_r;
  logic [3:0]  resp_flags;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference ALU: returns {cf, zf, vf, sf, result}.
  function automatic logic [35:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [3:0] fn);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (fn)
      4'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      4'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
      4'd2:  r = a & b;
      4'd3:  r = a | b;
      4'd4:  r = a ^ b;
      4'd13: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd15: r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return {c, (r == 32'd0), v, r[31], r};
  endfunction

  assign {alu_fl, alu_r} = alu_f(alu_a, alu_b, alu_fn);

  alu_arbiter #(.W(32), .FN_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_a0_i(req_a0), .req_b0_i(req_b0), .req_a1_i(req_a1), .req_b1_i(req_b1),
    .req_fn0_i(req_fn0), .req_fn1_i(req_fn1),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_fn_o(alu_fn),
    .alu_r_i(alu_r),
    .alu_cf_i(alu_fl[3]), .alu_zf_i(alu_fl[2]), .alu_vf_i(alu_fl[1]), .alu_sf_i(alu_fl[0]),
    .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_r_o(resp_r), .resp_flags_o(resp_flags), .busy_o(busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Who wins given the valid bits and the pointer: lone requester, else the pointer.
  function automatic int pick(input logic [1:0] v, input logic p);
    if (v == 2'b11) return int'(p);
    return v[1] ? 1 : 0;
  endfunction

  // Transaction-level model: one pending op with its age in cycles since acceptance.
  bit          m_busy;
  int          m_age, m_g;
  logic        m_prio;
  logic [31:0] m_a, m_b, m_r;
  logic [3:0]  m_fn, m_fl;
  logic [35:0] m_pend;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 1'b0; m_age = 0; m_g = 0; m_prio = 1'b0;
      m_a = 32'd0; m_b = 32'd0; m_fn = 4'd0; m_r = 32'd0; m_fl = 4'd0; m_pend = 36'd0;
    end else if (!m_busy) begin
      if (req_valid != 2'b00) begin
        m_g    = pick(req_valid, m_prio);
        m_prio = (m_g == 0);
        m_a    = (m_g == 1) ? req_a1  : req_a0;
        m_b    = (m_g == 1) ? req_b1  : req_b0;
        m_fn   = (m_g == 1) ? req_fn1 : req_fn0;
        m_pend = alu_f(m_a, m_b, m_fn);
        m_busy = 1'b1;
        m_age  = 1;
      end
    end else if (m_age == 1) begin
      {m_fl, m_r} = m_pend;
      m_age = 2;
    end else if (resp_ready[m_g]) begin
      m_busy = 1'b0;
    end
  end

  // Compare process: every output against the model, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] exp_rdy, exp_rv;
    exp_rdy = (!m_busy && req_valid != 2'b00) ? (2'b01 << pick(req_valid, m_prio)) : 2'b00;
    exp_rv  = (m_busy && m_age == 2) ? (2'b01 << m_g) : 2'b00;
    check("req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
    check("resp_valid", {62'd0, resp_valid}, {62'd0, exp_rv});
    check("busy", {63'd0, busy}, {63'd0, m_busy});
    check("alu_a", {32'd0, alu_a}, {32'd0, m_a});
    check("alu_b", {32'd0, alu_b}, {32'd0, m_b});
    check("alu_fn", {60'd0, alu_fn}, {60'd0, m_fn});
    check("resp_r", {32'd0, resp_r}, {32'd0, m_r});
    check("resp_flags", {60'd0, resp_flags}, {60'd0, m_fl});
  end

  int          grant_q[$];
  int          resp_p_q[$];
  logic [31:0] resp_r_q[$];
  logic [3:0]  resp_f_q[$];
  logic [1:0]  keep = 2'b00;

  // One cycle: log grants and completed responses, then drop accepted requests.
  task automatic step();
    logic [1:0] rdy;
    @(negedge clk);
    rdy = req_ready;
    if (rdy[0]) grant_q.push_back(0);
    if (rdy[1]) grant_q.push_back(1);
    for (int p = 0; p < 2; p++) begin
      if (resp_valid[p] && resp_ready[p]) begin
        resp_p_q.push_back(p);
        resp_r_q.push_back(resp_r);
        resp_f_q.push_back(resp_flags);
      end
    end
    @(posedge clk);
    #1;
    req_valid = req_valid & ~(rdy & ~keep);
  endtask

  task automatic clear_logs();
    grant_q.delete(); resp_p_q.delete(); resp_r_q.delete(); resp_f_q.delete();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((req_valid != 2'b00 || busy) && n < 40) begin
      step();
      n++;
    end
    check(name, {63'd0, (req_valid != 2'b00 || busy)}, 64'd0);
  endtask

  initial begin
    int base, p1_between;
    logic [31:0] held_r;
    logic [3:0]  held_f;

    rst = 1'b1;
    #12;
    check("reset_busy", {63'd0, busy}, 64'd0);
    check("reset_resp_valid", {62'd0, resp_valid}, 64'd0);
    check("reset_resp_r", {32'd0, resp_r}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single port-0 ADD, latency check.
    clear_logs();
    req_a0 = 32'd5; req_b0 = 32'd3; req_fn0 = 4'd0; req_valid = 2'b01;
    #1;
    check("t1_ready_same_cycle", {62'd0, req_ready}, 64'd1);
    step(); step();
    check("t1_no_resp_yet", resp_r_q.size(), 64'd0);
    step();
    check("t1_resp_count", resp_r_q.size(), 64'd1);
    if (resp_r_q.size() == 1) begin
      check("t1_resp_r", {32'd0, resp_r_q[0]}, 64'd8);
      check("t1_resp_flags", {60'd0, resp_f_q[0]}, 64'd0);
      check("t1_resp_port", resp_p_q[0], 64'd0);
    end
    drain("t1_drain");

    // Simultaneous dual request after a fresh reset.
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    clear_logs();
    req_a0 = 32'd1; req_b0 = 32'd2; req_fn0 = 4'd0;
    req_a1 = 32'd7; req_b1 = 32'd7; req_fn1 = 4'd1;
    req_valid = 2'b11;
    drain("t2_drain");
    check("t2_grants", grant_q.size(), 64'd2);
    check("t2_resps", resp_r_q.size(), 64'd2);
    if (grant_q.size() == 2 && resp_r_q.size() == 2) begin
      check("t2_first_grant", grant_q[0], 64'd0);
      check("t2_second_grant", grant_q[1], 64'd1);
      check("t2_r0", {32'd0, resp_r_q[0]}, 64'd3);
      check("t2_r1", {32'd0, resp_r_q[1]}, 64'd0);
      check("t2_f1", {60'd0, resp_f_q[1]}, 64'hC);
    end

    // Port 1 continuous, port 0 arrives once in the middle.
    clear_logs();
    keep = 2'b10;
    req_a1 = 32'h10; req_b1 = 32'h3; req_fn1 = 4'd4;
    req_valid = 2'b10;
    repeat (4) step();
    base = grant_q.size();
    req_a0 = 32'hF0; req_b0 = 32'h0F; req_fn0 = 4'd3;
    req_valid = req_valid | 2'b01;
    begin
      int n = 0;
      while (req_valid[0] && n < 20) begin step(); n++; end
    end
    check("t3_p0_served", {63'd0, req_valid[0]}, 64'd0);
    p1_between = 0;
    for (int i = base; i < grant_q.size(); i++) if (grant_q[i] == 1) p1_between++;
    check("t3_p0_wait_le1", {63'd0, (p1_between <= 1)}, 64'd1);
    keep = 2'b00;
    req_valid = 2'b00;
    drain("t3_drain");

    // Back-pressure on response with both requests pending.
    clear_logs();
    resp_ready = 2'b00;
    req_a0 = 32'd9; req_b0 = 32'd4; req_fn0 = 4'd1; req_valid = 2'b01;
    step();
    req_a1 = 32'd2; req_b1 = 32'd2; req_fn1 = 4'd0;
    req_valid = 2'b11;
    step();
    held_r = resp_r; held_f = resp_flags;
    check("t4_r_value", {32'd0, held_r}, 64'd5);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_busy", {63'd0, busy}, 64'd1);
      check("t4_ready_low", {62'd0, req_ready}, 64'd0);
      check("t4_valid_held", {62'd0, resp_valid}, 64'd1);
      check("t4_r_stable", {32'd0, resp_r}, {32'd0, held_r});
      check("t4_f_stable", {60'd0, resp_flags}, {60'd0, held_f});
    end
    resp_ready = 2'b01;
    step();
    check("t4_ready_after_release", {62'd0, req_ready}, 64'd2);
    resp_ready = 2'b11;
    drain("t4_drain");

    // Signed vs unsigned set-less-than on port 1.
    clear_logs();
    req_a1 = 32'hFFFF_FFFF; req_b1 = 32'd1; req_fn1 = 4'd13; req_valid = 2'b10;
    drain("t5a_drain");
    req_fn1 = 4'd15; req_valid = 2'b10;
    drain("t5b_drain");
    check("t5_resps", resp_r_q.size(), 64'd2);
    if (resp_r_q.size() == 2) begin
      check("t5_slt", {32'd0, resp_r_q[0]}, 64'd1);
      check("t5_sltu", {32'd0, resp_r_q[1]}, 64'd0);
    end

    // Reset during EXEC drops the operation and clears the pointer.
    clear_logs();
    req_a1 = 32'd3; req_b1 = 32'd3; req_fn1 = 4'd0; req_valid = 2'b10;
    step();
    rst = 1'b1;
    #1;
    check("t6_busy_async", {63'd0, busy}, 64'd0);
    check("t6_rv_async", {62'd0, resp_valid}, 64'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) step();
    check("t6_no_resp", resp_r_q.size(), 64'd0);
    clear_logs();
    req_a0 = 32'd4; req_b0 = 32'd6; req_fn0 = 4'd2;
    req_a1 = 32'd1; req_b1 = 32'd1; req_fn1 = 4'd0;
    req_valid = 2'b11;
    drain("t6_drain");
    check("t6_grants", grant_q.size(), 64'd2);
    if (grant_q.size() == 2) check("t6_first_grant", grant_q[0], 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
